// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word data-memory responder with programmable wait states
// Captures one load/store request in IDLE, retires it after WAIT_CYCLES, flags bad addresses.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [31:0] mem [DEPTH];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [31:0]           acc_off;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  enter_resp;
  logic                  mem_wr;

  // With zero wait states the capture edge is also the commit edge, so use live inputs in IDLE.
  always_comb begin
    acc_we    = (state_q == ST_IDLE) ? we    : we_q;
    acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    acc_off   = acc_addr - BASE_ADDR;
    acc_err   = (acc_off[1:0] != 2'b00)
              | (acc_addr < BASE_ADDR)
              | ({2'b00, acc_off[31:2]} >= DEPTH_W);
    acc_idx   = acc_off[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (NO_WAIT) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp && !acc_err && !acc_we) begin
      rdata_d = mem[acc_idx];
    end
    ready_d = enter_resp;
    err_d   = enter_resp & acc_err;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset; gating with rst keeps a write from landing on an edge where reset is held.
  assign mem_wr = enter_resp & ~acc_err & acc_we & rst;

  always_ff @(posedge clka) begin
    if (mem_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Two instances: WAIT_CYCLES=2 for latency/error/abort scenarios, WAIT_CYCLES=0 for back-to-back reads.
module tb_dmem_responder;
  localparam int W = 2;

  logic        clka = 1'b0;
  logic        rst;
  logic        req, we, ready, err, busy;
  logic [31:0] addr, wdata, rdata;
  logic        req0, we0, ready0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;

  int checks = 0;
  int errors = 0;

  bit [31:0] mm [bit [31:0]];
  bit [31:0] wr_addrs [$];
  bit [31:0] rdata_exp;

  always #5 clka = ~clka;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W), .BASE_ADDR(32'h0)) dut (
    .clka(clka), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clka(clka), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  function automatic bit exp_err(input bit [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  task automatic txn(input bit w, input bit [31:0] a, input bit [31:0] d, input bit noise);
    int n;
    bit e;
    @(negedge clka);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clka);
    n = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_capture addr=%h got %b want 1", a, busy); end
    req = 1'b0;
    if (noise) begin we = 1'($urandom); addr = $urandom; wdata = $urandom; end
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clka);
      n++;
      if (noise && ready !== 1'b1) begin
        req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
    end
    req = 1'b0;
    e = exp_err(a);
    checks++;
    if (n != W) begin errors++; $display("FAIL latency addr=%h got %0d want %0d", a, n, W); end
    checks++;
    if (err !== e) begin errors++; $display("FAIL err addr=%h got %b want %b", a, err, e); end
    if (!e) begin
      if (w) begin
        if (!mm.exists(a)) wr_addrs.push_back(a);
        mm[a] = d;
      end else begin
        rdata_exp = mm[a];
      end
    end
    checks++;
    if (rdata !== rdata_exp) begin errors++; $display("FAIL rdata addr=%h we=%b got %h want %h", a, w, rdata, rdata_exp); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_resp addr=%h got %b want 1", a, busy); end
    @(negedge clka);
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_resp addr=%h ready=%b busy=%b want 0 0", a, ready, busy);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h5555_AAAA;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    repeat (3) @(negedge clka);
    checks++;
    if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags ready=%b err=%b busy=%b want 0 0 0", ready, err, busy);
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++; $display("FAIL reset_dut0 ready=%b busy=%b rdata=%h want 0 0 0", ready0, busy0, rdata0);
    end
    rst = 1'b1;
    @(negedge clka);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_release_capture busy got %b want 1", busy); end
    n = 0;
    while (ready !== 1'b1 && n < 20) begin @(negedge clka); n++; end
    checks++;
    if (n != W || err !== 1'b0) begin
      errors++; $display("FAIL reset_release_resp latency=%0d err=%b want %0d 0", n, err, W);
    end
    mm[32'h40] = 32'h5555_AAAA;
    wr_addrs.push_back(32'h40);
    rdata_exp = 32'h0;
    @(negedge clka);
  endtask

  task automatic test_basic();
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 1'b0);
    txn(1'b1, 32'h12, 32'h1234_5678, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 1'b0);
    txn(1'b0, 32'h1000, 32'h0, 1'b0);
    txn(1'b1, 32'hFFC, 32'hA5A5_0FFC, 1'b0);
    txn(1'b0, 32'hFFC, 32'h0, 1'b0);
    txn(1'b0, 32'h40, 32'h0, 1'b0);
  endtask

  task automatic test_drop_and_abort();
    txn(1'b1, 32'h20, 32'h1111_1111, 1'b0);
    txn(1'b1, 32'h20, 32'hCAFE_F00D, 1'b1);
    txn(1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge clka);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BAD_F00D;
    @(negedge clka);
    req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL abort_async busy=%b ready=%b rdata=%h want 0 0 0", busy, ready, rdata);
    end
    @(negedge clka);
    rst = 1'b1;
    rdata_exp = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clka);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL abort_no_ready cycle=%0d got %b want 0", i, ready); end
    end
    txn(1'b0, 32'h20, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int r;
    bit [31:0] a;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (wr_addrs.size() == 0 || r < 4) begin
        a = {20'h0, 10'($urandom), 2'b00};
        txn(1'b1, a, $urandom, 1'($urandom));
      end else if (r < 8) begin
        a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        txn(1'b0, a, $urandom, 1'($urandom));
      end else if (r == 8) begin
        a = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
        txn(1'($urandom), a, $urandom, 1'b0);
      end else begin
        a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        txn(1'($urandom), a, $urandom, 1'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit [31:0] vals [3];
    bit        exp_rdy;
    int        pulses;
    for (int i = 0; i < 3; i++) begin
      vals[i] = $urandom;
      @(negedge clka);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'(i * 4 + 32'h100); wdata0 = vals[i];
      @(negedge clka);
      req0 = 1'b0;
      checks++;
      if (ready0 !== 1'b1 || err0 !== 1'b0 || busy0 !== 1'b1) begin
        errors++; $display("FAIL w0_write ready=%b err=%b busy=%b want 1 0 1", ready0, err0, busy0);
      end
    end
    @(negedge clka);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h104;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clka);
      exp_rdy = (i % 2) == 1;
      checks++;
      if (ready0 !== exp_rdy) begin errors++; $display("FAIL w0_ready cycle=%0d got %b want %b", i, ready0, exp_rdy); end
      if (ready0 === 1'b1) begin
        pulses++;
        checks++;
        if (busy0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== vals[1]) begin
          errors++; $display("FAIL w0_pulse busy=%b err=%b rdata=%h want 1 0 %h", busy0, err0, rdata0, vals[1]);
        end
      end
    end
    req0 = 1'b0;
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL w0_pulse_count got %0d want 3", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_and_abort();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clka);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
